// File: rtl/data_ram_if.sv
// Bus bundle for the data memory: word address, read/write mode, write data and registered read data.
// Signal names keep the processor datapath's original spelling so existing wiring maps one-to-one.
interface data_ram_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 11
) ();
  // Handshake: there is no valid/ready; every rising clk edge is a transfer whose
  // direction is chosen by isReading (1 = read into dataOut, 0 = write dataIn).
  logic [ADDR_WIDTH-1:0] address;
  logic                  isReading;
  logic [DATA_WIDTH-1:0] dataIn;
  logic [DATA_WIDTH-1:0] dataOut;

  modport master (
    output address,
    output isReading,
    output dataIn,
    input  dataOut
  );

  modport slave (
    input  address,
    input  isReading,
    input  dataIn,
    output dataOut
  );
endinterface

// File: rtl/data_ram.sv
// Single-port synchronous data memory, 2048 x 64, with registered read data (one-cycle latency).
// Reset clears only the output register; stored words survive it.
module data_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 2048
) (
  input  logic       clk,
  input  logic       reset,
  data_ram_if.slave  bus
);

  // Storage starts at all-zero; this initial value maps to the RAM init image.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [DATA_WIDTH-1:0] data_out_d;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] addr;

  assign addr = bus.address;

  // A write is suppressed while reset is asserted, so reset wins over the mode input.
  always_comb begin
    wr_en      = reset && !bus.isReading;
    data_out_d = data_out_q;
    if (bus.isReading) begin
      data_out_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= bus.dataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign bus.dataOut = data_out_q;

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: reset behaviour, write/read latency, boundary addresses,
// output hold on writes, reset-suppressed writes and mid-cycle input changes.
module tb_data_ram;

  logic clk;
  logic reset;
  int   tests_run;
  int   failed;

  data_ram_if #(.DATA_WIDTH(64), .ADDR_WIDTH(11)) bus ();

  data_ram dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: apply inputs, take one rising edge, then settle 1 time unit past it.
  task automatic cyc(input logic rd, input logic [10:0] a, input logic [63:0] d);
    bus.isReading = rd;
    bus.address   = a;
    bus.dataIn    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    tests_run     = 0;
    failed        = 0;
    reset         = 1'b0;
    bus.isReading = 1'b1;
    bus.address   = '0;
    bus.dataIn    = '0;

    // Reset held for two edges
    cyc(1'b1, 11'd0, 64'h0);
    cyc(1'b1, 11'd0, 64'h0);
    check("reset_dout", bus.dataOut, 64'h0);
    reset = 1'b1;
    cyc(1'b1, 11'd1024, 64'h0);
    check("read_init_1024", bus.dataOut, 64'h0);

    // Write 1024 then read a neighbour and the written word
    cyc(1'b0, 11'd1024, 64'hff04);
    check("write_hold_zero", bus.dataOut, 64'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 11'd1023, 64'h0);
      check("read_1023", bus.dataOut, 64'h0);
    end
    cyc(1'b1, 11'd1024, 64'h0);
    check("read_1024", bus.dataOut, 64'h000000000000ff04);

    // Write does not disturb dataOut
    cyc(1'b0, 11'd5, 64'hAAAA);
    check("write_hold_ff04", bus.dataOut, 64'hff04);
    cyc(1'b1, 11'd5, 64'h0);
    check("read_5", bus.dataOut, 64'hAAAA);

    // Boundary addresses and full-width data
    cyc(1'b0, 11'd0, 64'hFFFFFFFFFFFFFFFF);
    check("write_hold_aaaa", bus.dataOut, 64'hAAAA);
    cyc(1'b0, 11'd2047, 64'h0123456789ABCDEF);
    cyc(1'b1, 11'd0, 64'h0);
    check("read_0", bus.dataOut, 64'hFFFFFFFFFFFFFFFF);
    cyc(1'b1, 11'd2047, 64'h0);
    check("read_2047", bus.dataOut, 64'h0123456789ABCDEF);
    cyc(1'b1, 11'd2047, 64'h0);
    check("reread_2047", bus.dataOut, 64'h0123456789ABCDEF);
    cyc(1'b1, 11'd1, 64'h0);
    check("read_1_zero", bus.dataOut, 64'h0);

    // Write then read on consecutive edges
    cyc(1'b0, 11'd9, 64'h8000_0000_0000_1234);
    cyc(1'b1, 11'd9, 64'h0);
    check("wr_rd_9", bus.dataOut, 64'h8000_0000_0000_1234);

    // Reset discards a pending write
    reset = 1'b0;
    cyc(1'b0, 11'd1024, 64'h55);
    check("reset_wr_dout", bus.dataOut, 64'h0);
    cyc(1'b0, 11'd7, 64'h77);
    reset = 1'b1;
    cyc(1'b1, 11'd1024, 64'h0);
    check("post_reset_1024", bus.dataOut, 64'hff04);
    cyc(1'b1, 11'd7, 64'h0);
    check("post_reset_7", bus.dataOut, 64'h0);
    cyc(1'b1, 11'd9, 64'h0);
    check("post_reset_9", bus.dataOut, 64'h8000_0000_0000_1234);

    // Mid-cycle address change has no effect until the next rising edge
    cyc(1'b1, 11'd5, 64'h0);
    check("mid_pre", bus.dataOut, 64'hAAAA);
    bus.address = 11'd0;
    bus.dataIn  = 64'hDEAD;
    #2;
    check("mid_addr_hold", bus.dataOut, 64'hAAAA);
    @(negedge clk);
    #1;
    check("negedge_hold", bus.dataOut, 64'hAAAA);
    @(posedge clk);
    #1;
    check("mid_addr_new", bus.dataOut, 64'hFFFFFFFFFFFFFFFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
